// File: rtl/rom_seq_ctrl.sv
// rom_seq_ctrl: walks a 1-bit synchronous pattern ROM from a base address,
// packs the serial bits MSB-first into WORD_W-bit words and hands each word
// to a consumer over a valid/ready handshake.
module rom_seq_ctrl #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned WORD_W = 8,
  parameter int unsigned LEN_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_address,
  input  logic              rom_q,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam int unsigned ISS_W = $clog2(WORD_W + 1);
  localparam int unsigned CAP_W = $clog2(WORD_W);

  localparam logic [ISS_W-1:0] ISSUE_ONE  = ISS_W'(1);
  localparam logic [ISS_W-1:0] ISSUE_LAST = ISS_W'(WORD_W);
  localparam logic [CAP_W-1:0] CAP_ONE    = CAP_W'(1);
  localparam logic [CAP_W-1:0] CAP_LAST   = CAP_W'(WORD_W - 1);
  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [1:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ISS_W-1:0]  issue_q, issue_d;
  logic [CAP_W-1:0]  cap_q, cap_d;
  // pipe_q[0]: rom_address holds an issued address; pipe_q[1]: rom_q holds its bit
  logic [1:0]        pipe_q, pipe_d;

  // Next-state logic: command accept, address issue, bit capture and handshake
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    word_d  = word_q;
    valid_d = valid_q;
    rem_d   = rem_q;
    issue_d = issue_q;
    cap_d   = cap_q;
    pipe_d  = {pipe_q[0], 1'b0};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (len_words != '0) begin
            rem_d     = len_words;
            addr_d    = base_addr;
            issue_d   = ISSUE_ONE;
            pipe_d[0] = 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_FIN;
          end
        end
      end

      S_FETCH: begin
        if (issue_q != ISSUE_LAST) begin
          addr_d    = addr_q + ADDR_ONE;
          issue_d   = issue_q + ISSUE_ONE;
          pipe_d[0] = 1'b1;
        end
        if (pipe_q[1]) begin
          word_d = {word_q[WORD_W-2:0], rom_q};
          cap_d  = cap_q + CAP_ONE;
          if (cap_q == CAP_LAST) begin
            cap_d   = '0;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // word_valid is always high here, so word_ready alone completes the handshake
        if (word_ready) begin
          valid_d = 1'b0;
          rem_d   = rem_q - LEN_ONE;
          if (rem_q != LEN_ONE) begin
            addr_d    = addr_q + ADDR_ONE;
            issue_d   = ISSUE_ONE;
            pipe_d[0] = 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_FIN;
          end
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous abort on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      rem_q   <= '0;
      issue_q <= '0;
      cap_q   <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      rem_q   <= rem_d;
      issue_q <= issue_d;
      cap_q   <= cap_d;
      pipe_q  <= pipe_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rom_address = addr_q;
  assign word_data   = word_q;
  assign word_valid  = valid_q;

endmodule

// File: tb/tb_rom_seq_ctrl.sv
// Testbench for rom_seq_ctrl: behavioural ROM, scoreboard of expected words
// and done pulses, and a monitor that checks them as the DUT presents them.
module tb_rom_seq_ctrl;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  len_words = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_address;
  logic              rom_q = 1'b0;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;
  int          ready_mode = 0;

  bit rom_mem [DEPTH];

  typedef struct {
    logic [7:0] data;
    bit         first;
    bit         last;
    int         start_cyc;
  } exp_t;

  exp_t exp_q [$];
  int   done_q [$];

  rom_seq_ctrl #(
    .ADDR_W(ADDR_W),
    .WORD_W(WORD_W),
    .LEN_W (LEN_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .len_words  (len_words),
    .busy       (busy),
    .done       (done),
    .rom_address(rom_address),
    .rom_q      (rom_q),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous ROM: one cycle of read latency
  always @(posedge clock) rom_q <= rom_mem[rom_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [7:0] ref_word(input int base, input int w);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      r = {r[6:0], rom_mem[ADDR_W'((base + w * 8 + i) % DEPTH)]};
    return r;
  endfunction

  task automatic set_pat(input int a, input logic [7:0] p);
    for (int i = 0; i < 8; i++)
      rom_mem[ADDR_W'((a + i) % DEPTH)] = p[7-i];
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0) begin
      @(posedge clock); #1;
      n++;
      if (n > 3000) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle: busy=%b, expected 0 within 3000 cycles", busy);
        summary();
        $fatal(1, "timeout waiting for idle");
      end
    end
  endtask

  // Consumer ready: 0 = always ready, 1 = random, other = held low
  initial begin : ready_drv
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0:       word_ready = 1'b1;
        1:       word_ready = 1'($urandom_range(0, 1));
        default: word_ready = 1'b0;
      endcase
    end
  end

  // Monitor: checks word arrival timing, data, stability and done pulses
  initial begin : monitor
    exp_t       e;
    logic       prev_valid;
    logic [7:0] prev_data;
    bit         prev_hs;
    int         last_hs;
    prev_valid = 1'b0;
    prev_data  = '0;
    prev_hs    = 1'b0;
    last_hs    = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        if (word_valid && !prev_valid) begin
          if (exp_q.size() == 0)
            chk("unexpected_word", 32'(word_valid), 32'd0);
          else if (exp_q[0].first)
            chk("first_latency", cyc, exp_q[0].start_cyc + 9);
          else
            chk("next_latency", cyc, last_hs + 9);
        end
        if (word_valid && prev_valid && !prev_hs)
          chk("hold_stable", 32'(word_data), 32'(prev_data));
        prev_hs = 1'b0;
        if (word_valid && word_ready) begin
          prev_hs = 1'b1;
          last_hs = cyc + 1;
          if (exp_q.size() == 0) begin
            chk("extra_handshake", 32'(word_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("word_data", 32'(word_data), 32'(e.data));
            if (e.last) done_q.push_back(cyc + 2);
          end
        end
        if (done) begin
          chk("busy_at_done", 32'(busy), 32'd0);
          if (done_q.size() == 0)
            chk("unexpected_done", 32'(done), 32'd0);
          else
            chk("done_cycle", cyc, done_q.pop_front());
        end
        prev_valid = word_valid;
        prev_data  = word_data;
      end
    end
  end

  task automatic run_cmd(input int base, input int len, input bit trace);
    exp_t              e;
    int                e0;
    logic [ADDR_W-1:0] a0;
    wait_idle();
    a0        = rom_address;
    base_addr = ADDR_W'(base);
    len_words = LEN_W'(len);
    start     = 1'b1;
    e0        = cyc + 1;
    if (len == 0) begin
      done_q.push_back(e0 + 1);
    end else begin
      for (int w = 0; w < len; w++) begin
        e.data      = ref_word(base, w);
        e.first     = (w == 0);
        e.last      = (w == len - 1);
        e.start_cyc = e0;
        exp_q.push_back(e);
      end
    end
    @(posedge clock); #1;
    start     = 1'b0;
    base_addr = ADDR_W'($urandom);
    len_words = LEN_W'($urandom);
    if (len == 0) begin
      chk("zero_len_busy", 32'(busy), 32'd1);
      chk("zero_len_addr", 32'(rom_address), 32'(a0));
      @(posedge clock); #1;
      chk("zero_len_busy_drop", 32'(busy), 32'd0);
      chk("zero_len_no_word", 32'(word_valid), 32'd0);
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (trace)
          chk("addr_trace", 32'(rom_address), 32'((base + k) % DEPTH));
        if (k == 2) begin
          start     = 1'b1;
          base_addr = ADDR_W'($urandom);
          len_words = LEN_W'($urandom_range(1, 31));
        end
        if (k == 3) start = 1'b0;
        @(posedge clock); #1;
      end
    end
  endtask

  initial begin : stimulus
    int n;
    for (int i = 0; i < int'(DEPTH); i++) rom_mem[i] = 1'($urandom_range(0, 1));
    set_pat(26,  8'hF1);
    set_pat(46,  8'hF0);
    set_pat(86,  8'hD9);
    set_pat(94,  8'h8F);
    set_pat(124, 8'h00);

    #1 reset = 1'b1;
    #1;
    chk("reset_busy",  32'(busy),        32'd0);
    chk("reset_done",  32'(done),        32'd0);
    chk("reset_valid", 32'(word_valid),  32'd0);
    chk("reset_addr",  32'(rom_address), 32'd0);
    chk("reset_data",  32'(word_data),   32'd0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock); #1;

    // Abort mid-fetch: outputs clear at once, nothing follows
    ready_mode = 0;
    base_addr  = ADDR_W'(26);
    len_words  = LEN_W'(1);
    start      = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    chk("abort_busy",  32'(busy),        32'd0);
    chk("abort_valid", 32'(word_valid),  32'd0);
    chk("abort_done",  32'(done),        32'd0);
    chk("abort_addr",  32'(rom_address), 32'd0);
    @(posedge clock); #2;
    reset = 1'b0;
    repeat (20) begin @(posedge clock); #1; end
    chk("abort_idle", 32'(busy), 32'd0);

    // Directed commands with an always-ready consumer
    run_cmd(26, 1, 1'b1);
    run_cmd(86, 2, 1'b1);
    run_cmd(124, 1, 1'b1);
    run_cmd(0, 0, 1'b0);

    // Back-pressure: word must hold while ready is low
    ready_mode = 3;
    run_cmd(46, 1, 1'b1);
    n = 0;
    while (!word_valid && n < 20) begin @(posedge clock); #1; n++; end
    chk("hold_valid_seen", 32'(word_valid), 32'd1);
    for (int k = 0; k < 20; k++) begin
      chk("hold_valid", 32'(word_valid),  32'd1);
      chk("hold_data",  32'(word_data),   32'(ref_word(46, 0)));
      chk("hold_addr",  32'(rom_address), 32'd53);
      @(posedge clock); #1;
    end
    ready_mode = 0;

    // Randomized commands with a randomly stalling consumer
    ready_mode = 1;
    for (int t = 0; t < 14; t++)
      run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 4)), 1'b1);

    wait_idle();
    repeat (5) begin @(posedge clock); #1; end
    chk("words_outstanding", 32'(exp_q.size()),  32'd0);
    chk("done_outstanding",  32'(done_q.size()), 32'd0);
    summary();
    $finish;
  end

endmodule
